trace_dumper: RTL

TRACE_DUMPER -- requirements
Module: trace_dumper

---
 rtl/trace_dumper_pkg.sv | 28 ++
 rtl/trace_dumper.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/trace_dumper_pkg.sv
// Shared definitions for the trace dumper: FSM state codes, beat tag
// constants and the registered beat payload record.
package trace_dumper_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned ST_W   = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t S_IDLE      = 2'd0;
  localparam state_t S_SEND_PC   = 2'd1;
  localparam state_t S_SEND_INST = 2'd2;
  localparam state_t S_SEND_REG  = 2'd3;

  localparam logic [TAG_W-1:0] TAG_PC       = 6'd0;
  localparam logic [TAG_W-1:0] TAG_INST     = 6'd1;
  localparam logic [TAG_W-1:0] TAG_REG_BASE = 6'd2;

  // One outgoing beat as held on the tx port.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              last;
  } beat_t;

endpackage

// File: rtl/trace_dumper.sv
// trace_dumper: on a snap request, freezes the CPU and streams a frame of
// pc, instruction and NREGS register-file words over a valid/ready port.
//   clk, rst        clock, async active-low reset
//   snap            capture request (honoured only when idle)
//   pc_in, inst_in  values captured at the snap edge
//   rf_raddr        register-file read address for the next register beat
//   rf_rdata        register-file read data for rf_raddr
//   halt_req        CPU freeze while a frame is in flight
//   tx_valid/ready  beat handshake; tx_data/tx_tag/tx_last beat payload
//   dropped         saturating count of snaps ignored while busy
module trace_dumper
  import trace_dumper_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNTW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snap,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] inst_in,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              halt_req,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [TAG_W-1:0]  tx_tag,
  output logic              tx_last,
  output logic [CNTW-1:0]   dropped
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d, idx_nx;
  logic [DATA_W-1:0]   inst_q, inst_d;
  beat_t               beat_q, beat_d;
  logic                valid_d, halt_d;
  logic [ADDR_W-1:0]   raddr_d;
  logic [CNTW-1:0]     dropped_d;
  logic                xfer;

  assign tx_data = beat_q.data;
  assign tx_tag  = beat_q.tag;
  assign tx_last = beat_q.last;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      inst_q   <= '0;
      beat_q   <= '0;
      tx_valid <= 1'b0;
      halt_req <= 1'b0;
      rf_raddr <= '0;
      dropped  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      inst_q   <= inst_d;
      beat_q   <= beat_d;
      tx_valid <= valid_d;
      halt_req <= halt_d;
      rf_raddr <= raddr_d;
      dropped  <= dropped_d;
    end
  end

  // Next state and next registered outputs; payload only moves on a transfer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    inst_d    = inst_q;
    beat_d    = beat_q;
    valid_d   = tx_valid;
    halt_d    = halt_req;
    raddr_d   = rf_raddr;
    dropped_d = dropped;
    xfer      = tx_valid & tx_ready;
    idx_nx    = idx_q + ADDR_W'(1);

    // Any snap outside IDLE is lost, including one on the final transfer edge.
    if (snap && (state_q != S_IDLE) && (dropped != '1)) begin
      dropped_d = dropped + CNTW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (snap) begin
          state_d = S_SEND_PC;
          inst_d  = inst_in;
          beat_d  = '{data: pc_in, tag: TAG_PC, last: 1'b0};
          valid_d = 1'b1;
          halt_d  = 1'b1;
          raddr_d = '0;
        end
      end
      S_SEND_PC: begin
        if (xfer) begin
          state_d = S_SEND_INST;
          beat_d  = '{data: inst_q, tag: TAG_INST, last: 1'b0};
          raddr_d = '0;
        end
      end
      S_SEND_INST: begin
        if (xfer) begin
          state_d = S_SEND_REG;
          idx_d   = '0;
          beat_d  = '{data: rf_rdata, tag: TAG_REG_BASE, last: (LAST_IDX == '0)};
          raddr_d = (LAST_IDX == '0) ? '0 : ADDR_W'(1);
        end
      end
      S_SEND_REG: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d     = S_IDLE;
            valid_d     = 1'b0;
            halt_d      = 1'b0;
            beat_d.last = 1'b0;
            raddr_d     = '0;
          end else begin
            idx_d   = idx_nx;
            beat_d  = '{data: rf_rdata,
                        tag:  TAG_REG_BASE + TAG_W'(idx_nx),
                        last: (idx_nx == LAST_IDX)};
            // Prefetch address for the beat after this one, none after the last.
            raddr_d = (idx_nx == LAST_IDX) ? '0 : idx_nx + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        halt_d  = 1'b0;
      end
    endcase
  end

endmodule
